// File: rtl/subtitle_text_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : subtitle_pkg
// Purpose : Shared constants for the subtitle text buffer: FSM state
//           encoding, control codes, printable range and screen geometry.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package subtitle_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;
  localparam logic [1:0] ST_FILL   = 2'd3;

  localparam logic [7:0] CODE_CR  = 8'h0D;
  localparam logic [7:0] CODE_FF  = 8'h0C;
  localparam logic [7:0] CODE_BS  = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Scroll copies addresses 0..239; the last row starts at 240
  localparam logic [7:0] SCROLL_LAST   = 8'd240;
  localparam logic [7:0] LAST_ROW_BASE = 8'hF0;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/subtitle_text_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : subtitle_text_buffer_if
// Purpose : Byte input handshake, display read port and status of the
//           subtitle text buffer.
// Signals : data_in/data_valid/data_ready  byte stream handshake
//           char_xy/char_code              display read address / data
//           cursor_xy/busy                 status
// Rev     : 1.0  initial release
// ============================================================================
interface subtitle_text_buffer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] char_xy;
  logic [7:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  modport master (
    output data_in, data_valid, char_xy,
    input  data_ready, char_code, cursor_xy, busy
  );

  modport slave (
    input  data_in, data_valid, char_xy,
    output data_ready, char_code, cursor_xy, busy
  );
endinterface
`default_nettype wire

// File: rtl/subtitle_text_buffer_char_ram.sv
`default_nettype none
// ============================================================================
// Module  : subtitle_char_ram
// Purpose : 256 x 8 character store. Port A: synchronous display read.
//           Port B: synchronous read plus write, used by the control FSM.
// Ports   : clk, rst (active-low, resets only the read registers)
//           a_addr/a_data                  display read
//           b_rd_addr/b_rd_data            FSM read
//           b_we/b_wr_addr/b_wr_data       FSM write
// Rev     : 1.0  initial release
// ============================================================================
module subtitle_char_ram (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [7:0] a_addr,
  output logic      [7:0] a_data,
  input  wire logic [7:0] b_rd_addr,
  output logic      [7:0] b_rd_data,
  input  wire logic       b_we,
  input  wire logic [7:0] b_wr_addr,
  input  wire logic [7:0] b_wr_data
);

  logic [7:0] mem [256];

  // Array itself is never reset; contents are rebuilt by the clear sequence
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_wr_addr] <= b_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_data    <= 8'h00;
      b_rd_data <= 8'h00;
    end else begin
      a_data    <= mem[a_addr];
      b_rd_data <= mem[b_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/subtitle_text_buffer.sv
`default_nettype none
// ============================================================================
// Module  : subtitle_text_buffer
// Purpose : 16x16 subtitle character buffer. Accepts printable bytes and
//           CR / BS / FF control codes, maintains a cursor, scrolls one
//           row when the cursor runs off the bottom, and serves a
//           one-cycle-latency read port to the character-draw stage.
// Ports   : clk  single clock
//           rst  asynchronous active-low reset
//           bus  subtitle_text_buffer_if.slave (handshake, display, status)
// Rev     : 1.0  initial release
// ============================================================================
module subtitle_text_buffer
  import subtitle_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR     = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  subtitle_text_buffer_if.slave  bus
);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [3:0] row;
  logic [3:0] col;
  logic       booting;   // set until the first post-reset clear finishes

  logic       accept;
  logic       printable;
  logic       line_end;  // byte finishes the current line
  logic       we;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  assign accept    = bus.data_valid && (state == ST_IDLE);
  assign printable = is_printable(bus.data_in);
  assign line_end  = (printable && (col == 4'hF)) || (bus.data_in == CODE_CR);

  assign bus.data_ready = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.cursor_xy  = {row, col};

  always_comb begin
    we      = 1'b0;
    wr_addr = 8'h00;
    wr_data = BLANK_CHAR;
    rd_addr = 8'h00;
    case (state)
      ST_IDLE: begin
        if (accept && printable) begin
          we      = 1'b1;
          wr_addr = {row, col};
          wr_data = bus.data_in;
        end else if (accept && (bus.data_in == CODE_BS) && (col != 4'h0)) begin
          we      = 1'b1;
          wr_addr = {row, col - 4'd1};
        end
      end
      ST_CLEAR: begin
        we      = !(booting && !CLEAR_ON_RESET);
        wr_addr = cnt;
      end
      ST_SCROLL: begin
        // Read a+16 this cycle, write it to a on the next one
        rd_addr = cnt + 8'd16;
        if (cnt != 8'd0) begin
          we      = 1'b1;
          wr_addr = cnt - 8'd1;
          wr_data = rd_data;
        end
      end
      default: begin  // ST_FILL
        we      = 1'b1;
        wr_addr = LAST_ROW_BASE | cnt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      cnt     <= 8'd0;
      row     <= 4'd0;
      col     <= 4'd0;
      booting <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (printable) begin
              col <= col + 4'd1;
            end else if (bus.data_in == CODE_CR) begin
              col <= 4'd0;
            end else if ((bus.data_in == CODE_BS) && (col != 4'd0)) begin
              col <= col - 4'd1;
            end else if (bus.data_in == CODE_FF) begin
              row   <= 4'd0;
              col   <= 4'd0;
              cnt   <= 8'd0;
              state <= ST_CLEAR;
            end
            // Running off the bottom row keeps the cursor on row 15
            if (line_end) begin
              if (row == 4'hF) begin
                cnt   <= 8'd0;
                state <= ST_SCROLL;
              end else begin
                row <= row + 4'd1;
              end
            end
          end
        end
        ST_CLEAR: begin
          if (booting && !CLEAR_ON_RESET) begin
            booting <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'hFF) begin
              booting <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_SCROLL: begin
          cnt <= cnt + 8'd1;
          if (cnt == SCROLL_LAST) begin
            cnt   <= 8'd0;
            state <= ST_FILL;
          end
        end
        default: begin  // ST_FILL
          cnt <= cnt + 8'd1;
          if (cnt == 8'd15) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  subtitle_char_ram u_ram (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (bus.char_xy),
    .a_data    (bus.char_code),
    .b_rd_addr (rd_addr),
    .b_rd_data (rd_data),
    .b_we      (we && rst),
    .b_wr_addr (wr_addr),
    .b_wr_data (wr_data)
  );

endmodule
`default_nettype wire
